// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - PC, ROM read issue and fetch buffer feeding the instruction decoder
module instruction_fetch_unit #(
    parameter int          ADDR_WIDTH  = 8,
    parameter int          INSTR_WIDTH = 20,
    parameter int          FIFO_DEPTH  = 2,
    parameter logic [3:0]  HALT_OPCODE = 4'hF
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_WIDTH-1:0]  start_addr,
    output logic [ADDR_WIDTH-1:0]  imem_addr,
    output logic                   imem_rd_en,
    input  logic [INSTR_WIDTH-1:0] imem_rdata,
    output logic [INSTR_WIDTH-1:0] instr_out,
    output logic [ADDR_WIDTH-1:0]  instr_pc,
    output logic                   instr_valid,
    input  logic                   instr_ready,
    output logic                   halted,
    output logic                   busy
);
    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_FETCH,
        S_HALTED
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_WIDTH-1:0]  pc_q;
    logic                   inflight_q;
    logic [ADDR_WIDTH-1:0]  inflight_pc_q;
    logic                   halt_seen_q;
    logic [INSTR_WIDTH-1:0] mem_word [FIFO_DEPTH];
    logic [ADDR_WIDTH-1:0]  mem_pc   [FIFO_DEPTH];
    logic [PW-1:0]          wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]          count_q;

    logic          push, pop, issue, start_ok, rdata_halt, head_halt;
    logic [CW:0]   occupancy;

    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push       = inflight_q;
    assign pop        = (count_q != '0) && instr_ready;
    assign rdata_halt = inflight_q && (imem_rdata[INSTR_WIDTH-1 -: 4] == HALT_OPCODE);
    assign head_halt  = (mem_word[rd_ptr_q][INSTR_WIDTH-1 -: 4] == HALT_OPCODE);
    assign occupancy  = {1'b0, count_q} + (CW+1)'(inflight_q);
    assign start_ok   = start && (state_q != S_FETCH);

    // A read may be issued into a full buffer only when the head leaves this cycle;
    // the returning HALT word blocks the read that would otherwise follow it.
    assign issue = (state_q == S_FETCH) && !halt_seen_q && !rdata_halt &&
                   ((occupancy < (CW+1)'(FIFO_DEPTH)) ||
                    ((occupancy == (CW+1)'(FIFO_DEPTH)) && pop));

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:   if (start) state_d = S_FETCH;
            S_FETCH:  if (pop && head_halt) state_d = S_HALTED;
            S_HALTED: if (start) state_d = S_FETCH;
            default:  state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= S_IDLE;
            pc_q          <= '0;
            inflight_q    <= 1'b0;
            inflight_pc_q <= '0;
            halt_seen_q   <= 1'b0;
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
        end else begin
            state_q <= state_d;
            if (start_ok) begin
                pc_q        <= start_addr;
                inflight_q  <= 1'b0;
                halt_seen_q <= 1'b0;
                wr_ptr_q    <= '0;
                rd_ptr_q    <= '0;
                count_q     <= '0;
            end else begin
                inflight_q <= issue;
                if (issue) begin
                    pc_q          <= pc_q + 1'b1;
                    inflight_pc_q <= pc_q;
                end
                if (push) begin
                    wr_ptr_q <= ptr_next(wr_ptr_q);
                    if (rdata_halt) halt_seen_q <= 1'b1;
                end
                if (pop) rd_ptr_q <= ptr_next(rd_ptr_q);
                case ({push, pop})
                    2'b10:   count_q <= count_q + 1'b1;
                    2'b01:   count_q <= count_q - 1'b1;
                    default: count_q <= count_q;
                endcase
            end
        end
    end

    // Storage needs no reset: the head is only visible while count_q is non-zero.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_word[wr_ptr_q] <= imem_rdata;
            mem_pc[wr_ptr_q]   <= inflight_pc_q;
        end
    end

    assign imem_addr   = pc_q;
    assign imem_rd_en  = issue;
    assign instr_valid = (count_q != '0);
    assign instr_out   = instr_valid ? mem_word[rd_ptr_q] : '0;
    assign instr_pc    = instr_valid ? mem_pc[rd_ptr_q] : '0;
    assign halted      = (state_q == S_HALTED);
    assign busy        = (state_q == S_FETCH);
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - scoreboard bench for instruction_fetch_unit
module tb_instruction_fetch_unit;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  start_addr = 8'h00;
    logic [7:0]  imem_addr;
    logic        imem_rd_en;
    logic [19:0] imem_rdata = 20'h0;
    logic [19:0] instr_out;
    logic [7:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic        halted;
    logic        busy;

    instruction_fetch_unit dut (
        .clk(clk), .rst(rst), .start(start), .start_addr(start_addr),
        .imem_addr(imem_addr), .imem_rd_en(imem_rd_en), .imem_rdata(imem_rdata),
        .instr_out(instr_out), .instr_pc(instr_pc), .instr_valid(instr_valid),
        .instr_ready(instr_ready), .halted(halted), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  pc;
        logic [19:0] w;
    } exp_t;

    logic [19:0] rom [256];
    exp_t        sb_q [$];
    int          n_checks = 0;
    int          n_fail = 0;
    logic        halt_pending = 1'b0;
    logic        forbid_en = 1'b0;
    logic [7:0]  forbid_addr = 8'h00;

    // Unread cycles return a HALT-looking word so a stray capture cannot go unnoticed.
    always @(posedge clk) begin
        if (imem_rd_en) imem_rdata <= rom[imem_addr];
        else            imem_rdata <= 20'hF0BAD;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (halt_pending) begin
            check("halted_after_halt", 32'(halted), 1);
            check("busy_after_halt", 32'(busy), 0);
            halt_pending = 1'b0;
        end
        if (!rst && instr_valid && instr_ready) begin
            if (sb_q.size() == 0) begin
                check("sb_underflow", 32'(sb_q.size()), 1);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("instr_pc", 32'(instr_pc), 32'(e.pc));
                check("instr_out", 32'(instr_out), 32'(e.w));
                check("halted_before_halt", 32'(halted), 0);
                if (e.w[19:16] == 4'hF) halt_pending = 1'b1;
            end
        end
        if (forbid_en)
            check("no_fetch_past_halt", 32'(imem_rd_en && imem_addr == forbid_addr), 0);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rom_init();
        for (int a = 0; a < 256; a++) rom[a] = {4'h1, 8'h00, 8'(a)};
    endtask

    task automatic push_range(input logic [7:0] lo, input int n);
        for (int i = 0; i < n; i++) begin
            exp_t e;
            e.pc = lo + 8'(i);
            e.w  = rom[e.pc];
            sb_q.push_back(e);
        end
    endtask

    task automatic do_start(input logic [7:0] a);
        start_addr = a;
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic wait_halted(input int budget);
        int k = 0;
        while (!halted && k < budget) begin
            step();
            k++;
        end
        check("halt_timeout", 32'(halted), 1);
        step();
        check("sb_drained", 32'(sb_q.size()), 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        instr_ready = 1'b0;
        forbid_en = 1'b0;
        sb_q.delete();
        step();
        step();
        rst = 1'b0;
    endtask

    initial begin
        rom_init();
        step();
        step();
        check("rst_imem_addr", 32'(imem_addr), 0);
        check("rst_rd_en", 32'(imem_rd_en), 0);
        check("rst_valid", 32'(instr_valid), 0);
        check("rst_instr_out", 32'(instr_out), 0);
        check("rst_instr_pc", 32'(instr_pc), 0);
        check("rst_halted", 32'(halted), 0);
        check("rst_busy", 32'(busy), 0);
        rst = 1'b0;
        step();

        // Latency, stall with start ignored during FETCH, then halt at 0x30
        rom[8'h30] = 20'hF0000;
        forbid_addr = 8'h31;
        forbid_en = 1'b1;
        push_range(8'h10, 33);
        instr_ready = 1'b1;
        do_start(8'h10);
        check("lat_rd_en_c1", 32'(imem_rd_en), 1);
        check("lat_addr_c1", 32'(imem_addr), 32'h10);
        check("lat_busy_c1", 32'(busy), 1);
        check("lat_valid_c1", 32'(instr_valid), 0);
        step();
        check("lat_valid_c2", 32'(instr_valid), 0);
        step();
        check("lat_valid_c3", 32'(instr_valid), 1);
        check("lat_pc_c3", 32'(instr_pc), 32'h10);
        for (int i = 0; i < 4; i++) step();
        instr_ready = 1'b0;
        step();
        step();
        start_addr = 8'h80;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("stall_rd_en", 32'(imem_rd_en), 0);
            check("stall_valid", 32'(instr_valid), 1);
            check("stall_head_pc", 32'(instr_pc), 32'(sb_q[0].pc));
            step();
        end
        instr_ready = 1'b1;
        wait_halted(200);
        check("halted_busy", 32'(busy), 0);

        // Restart from HALTED at 0x20 with HALT at 0x22
        rom[8'h22] = 20'hF0000;
        forbid_addr = 8'h23;
        push_range(8'h20, 3);
        do_start(8'h20);
        check("restart_halted", 32'(halted), 0);
        check("restart_busy", 32'(busy), 1);
        check("restart_rd_en", 32'(imem_rd_en), 1);
        check("restart_addr", 32'(imem_addr), 32'h20);
        wait_halted(50);

        // HALT at 0x12: nothing past it fetched
        do_reset();
        rom_init();
        rom[8'h12] = 20'hF0000;
        forbid_addr = 8'h13;
        forbid_en = 1'b1;
        push_range(8'h10, 3);
        instr_ready = 1'b1;
        do_start(8'h10);
        wait_halted(50);

        // PC wrap 0xFE -> 0x01 without a stall
        do_reset();
        rom_init();
        rom[8'h01] = 20'hF0000;
        forbid_addr = 8'h02;
        forbid_en = 1'b1;
        push_range(8'hFE, 4);
        instr_ready = 1'b1;
        do_start(8'hFE);
        step();
        step();
        for (int i = 0; i < 4; i++) begin
            check("wrap_no_gap", 32'(instr_valid), 1);
            step();
        end
        wait_halted(20);

        // Reset mid-stream with buffered and in-flight words
        do_reset();
        rom_init();
        push_range(8'h50, 40);
        instr_ready = 1'b1;
        do_start(8'h50);
        for (int i = 0; i < 6; i++) step();
        rst = 1'b1;
        instr_ready = 1'b0;
        sb_q.delete();
        step();
        check("midrst_valid", 32'(instr_valid), 0);
        check("midrst_rd_en", 32'(imem_rd_en), 0);
        check("midrst_halted", 32'(halted), 0);
        check("midrst_busy", 32'(busy), 0);
        rst = 1'b0;
        instr_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check("midrst_no_stale", 32'(instr_valid), 0);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
